// File: rtl/rand_arbiter_if.sv
// ============================================================================
// rand_arbiter_if : requester/random-source bundle for rand_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rand_arbiter_if #(
  parameter int N = 4
) ();
  logic [N-1:0]   req;
  logic [4*N-1:0] max;
  logic [3:0]     rand_val;
  logic [N-1:0]   ack;
  logic [3:0]     value;
  logic           busy;

  modport master (
    output req, max, rand_val,
    input  ack, value, busy
  );

  modport slave (
    input  req, max, rand_val,
    output ack, value, busy
  );
endinterface

`default_nettype wire

// File: rtl/rand_arbiter.sv
// ============================================================================
// rand_arbiter : round-robin sharing of one LFSR nibble, rejection-sampled
// Revision: 1.0
// ============================================================================
`default_nettype none

module rand_arbiter #(
  parameter int N         = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rand_arbiter_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, rr_ptr_nx;
  logic [IW-1:0]   idx_r, idx_nx;
  logic [3:0]      max_r, max_nx;
  logic [3:0]      tries_r, tries_nx;
  logic [3:0]      value_r, value_nx;

  logic [3:0]      max_arr [N];
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   pick_pos;
  logic [3:0]      pick_max;

  for (genvar g = 0; g < N; g++) begin : g_max_unpack
    assign max_arr[g] = bus.max[4*g +: 4];
  end

  // Scan from the farthest offset down so the one nearest rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_pos   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pick_pos = IW'((int'(rr_ptr) + off) % N);
      if (bus.req[pick_pos]) begin
        pick_valid = 1'b1;
        pick_idx   = pick_pos;
      end
    end
  end

  assign pick_max = (max_arr[pick_idx] == 4'd0) ? 4'd15 : max_arr[pick_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      idx_r   <= '0;
      max_r   <= 4'd0;
      tries_r <= 4'd0;
      value_r <= 4'd0;
    end else begin
      state   <= state_nx;
      rr_ptr  <= rr_ptr_nx;
      idx_r   <= idx_nx;
      max_r   <= max_nx;
      tries_r <= tries_nx;
      value_r <= value_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    idx_nx    = idx_r;
    max_nx    = max_r;
    tries_nx  = tries_r;
    value_nx  = value_r;
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          idx_nx   = pick_idx;
          max_nx   = pick_max;
          tries_nx = 4'd0;
          state_nx = S_DRAW;
        end
      end
      S_DRAW: begin
        if (bus.rand_val <= max_r) begin
          value_nx = bus.rand_val;
          state_nx = S_DONE;
        end else if (tries_r == 4'(MAX_TRIES - 1)) begin
          // Out of retries: hand out the bound itself so the grant never stalls.
          value_nx = max_r;
          state_nx = S_DONE;
        end else begin
          tries_nx = tries_r + 4'd1;
        end
      end
      S_DONE: begin
        rr_ptr_nx = (idx_r == IW'(N - 1)) ? '0 : idx_r + 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.ack   = (state == S_DONE) ? ({{(N-1){1'b0}}, 1'b1} << idx_r) : '0;
  assign bus.value = (state == S_DONE) ? value_r : 4'd0;
  assign bus.busy  = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rand_arbiter.sv
// ============================================================================
// tb_rand_arbiter : directed and randomized checks against a transaction model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rand_arbiter;

  localparam int N         = 4;
  localparam int MAX_TRIES = 8;

  typedef logic [3:0] draws_t [MAX_TRIES];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rand_arbiter_if #(.N(N)) bus ();

  rand_arbiter #(.N(N), .MAX_TRIES(MAX_TRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ptr  = 0;

  // Transaction-level model: who wins, what value, how many cycles to ack.
  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (req[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic void model_draw(input logic [3:0] raw, input draws_t d,
                                     output logic [3:0] v, output int lat);
    int bound;
    bound = (raw == 4'd0) ? 15 : int'(raw);
    for (int t = 0; t < MAX_TRIES; t++) begin
      if (int'(d[t]) <= bound) begin
        v   = d[t];
        lat = t + 2;
        return;
      end
    end
    v   = 4'(bound);
    lat = MAX_TRIES + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_draws(output draws_t d);
    for (int t = 0; t < MAX_TRIES; t++) d[t] = 4'($urandom_range(1, 15));
  endtask

  // Drives one transaction from idle; observes ack timing and the cycle after.
  task automatic run_txn(input draws_t d, input bit mid_en,
                         input logic [N-1:0] req_mid, input logic [4*N-1:0] max_mid,
                         output logic [N-1:0] ack_o, output logic [3:0] val_o,
                         output int lat, output logic [N-1:0] ack_after,
                         output logic busy_after);
    int di;
    lat = -1; ack_o = '0; val_o = '0; ack_after = '1; busy_after = 1'b1;
    for (int c = 1; c <= MAX_TRIES + 4; c++) begin
      di = (c < 2) ? 0 : ((c - 2 < MAX_TRIES) ? c - 2 : MAX_TRIES - 1);
      bus.rand_val = d[di];
      tick();
      if (mid_en && c == 1) begin
        bus.req = req_mid;
        bus.max = max_mid;
      end
      if (bus.ack !== '0) begin
        lat   = c;
        ack_o = bus.ack;
        val_o = bus.value;
        break;
      end
    end
    if (lat > 0) begin
      tick();
      ack_after  = bus.ack;
      busy_after = bus.busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req = '0; bus.max = '0; bus.rand_val = 4'd1;
    repeat (2) tick();
    n_checks += 3;
    if (bus.ack !== '0)     begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
    if (bus.value !== 4'd0) begin n_fail++; $display("FAIL reset_value: got %0d expected 0", bus.value); end
    if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    #4 rst_n = 1'b1;
    tick();
    // Reset while the ack pulse is on the outputs.
    bus.req = 4'b0001; bus.max = 16'h0009; bus.rand_val = 4'd5;
    tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL draw_busy: got %b expected 1", bus.busy); end
    tick();
    n_checks++;
    if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL pre_reset_ack: got %b expected 0001", bus.ack); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (bus.ack !== '0)     begin n_fail++; $display("FAIL async_ack: got %b expected 0", bus.ack); end
    if (bus.value !== 4'd0) begin n_fail++; $display("FAIL async_value: got %0d expected 0", bus.value); end
    if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL async_busy: got %b expected 0", bus.busy); end
    #2 rst_n = 1'b1;
    tick();
    // Reset in the middle of a rejection run; the grant must be lost.
    bus.req = 4'b0001; bus.max = 16'h0002; bus.rand_val = 4'd15;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL middraw_busy: got %b expected 0", bus.busy); end
    bus.req = '0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.ack !== '0 || bus.value !== 4'd0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset: got ack=%b value=%0d busy=%b expected all 0",
                 bus.ack, bus.value, bus.busy);
      end
    end
    exp_ptr = 0;
  endtask

  task automatic test_directed(input string name, input logic [3:0] bound,
                               input draws_t d, input int exp_lat, input logic [3:0] exp_val);
    logic [N-1:0] ack, ack_after; logic [3:0] val; int lat; logic busy_after;
    bus.req = 4'b0001; bus.max = {12'h000, bound};
    run_txn(d, 1'b0, '0, '0, ack, val, lat, ack_after, busy_after);
    bus.req = '0;
    n_checks += 4;
    if (ack !== 4'b0001)  begin n_fail++; $display("FAIL %s_ack: got %b expected 0001", name, ack); end
    if (val !== exp_val)  begin n_fail++; $display("FAIL %s_value: got %0d expected %0d", name, val, exp_val); end
    if (lat != exp_lat)   begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    if (ack_after !== '0 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL %s_pulse: got ack=%b busy=%b after pulse expected 0", name, ack_after, busy_after);
    end
    exp_ptr = 1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] ack, ack_after; logic [3:0] val; int lat; logic busy_after;
    logic [N-1:0] order [5];
    draws_t d;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0; tick(); #4 rst_n = 1'b1; tick();
    exp_ptr = 0;
    bus.req = 4'b1111; bus.max = 16'h0000;
    for (int t = 0; t < 5; t++) begin
      rand_draws(d);
      run_txn(d, 1'b0, '0, '0, ack, val, lat, ack_after, busy_after);
      n_checks += 3;
      if (ack !== order[t] || ack !== (4'b0001 << model_pick(bus.req, exp_ptr))) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", t, ack, order[t]);
      end
      if (val !== d[0]) begin n_fail++; $display("FAIL rr_value%0d: got %0d expected %0d", t, val, d[0]); end
      if (lat != 2)     begin n_fail++; $display("FAIL rr_latency%0d: got %0d expected 2", t, lat); end
      exp_ptr = (exp_ptr + 1) % N;
    end
    bus.req = '0;
  endtask

  task automatic test_drop_mid_draw();
    logic [N-1:0] ack, ack_after; logic [3:0] val, mval; int lat, mlat, w;
    logic busy_after;
    draws_t d;
    d = '{4'd10, 4'd10, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    bus.req = 4'b0100; bus.max = 16'h0400;
    run_txn(d, 1'b1, 4'b0000, 16'h0F00, ack, val, lat, ack_after, busy_after);
    n_checks += 3;
    if (ack !== 4'b0100) begin n_fail++; $display("FAIL drop_ack: got %b expected 0100", ack); end
    if (val !== 4'd1)    begin n_fail++; $display("FAIL drop_value: got %0d expected 1", val); end
    if (lat != 4)        begin n_fail++; $display("FAIL drop_latency: got %0d expected 4", lat); end
    exp_ptr = 3;
    // rr_ptr now sits at 3, so requester 0 outranks requester 2.
    bus.req = 4'b0101; bus.max = 16'($urandom);
    rand_draws(d);
    w = model_pick(bus.req, exp_ptr);
    model_draw(bus.max[4*w +: 4], d, mval, mlat);
    run_txn(d, 1'b0, '0, '0, ack, val, lat, ack_after, busy_after);
    bus.req = '0;
    n_checks += 2;
    if (ack !== 4'b0001) begin n_fail++; $display("FAIL after_drop_ack: got %b expected 0001", ack); end
    if (val !== mval || lat != mlat) begin
      n_fail++; $display("FAIL after_drop_value: got %0d/%0d expected %0d/%0d", val, lat, mval, mlat);
    end
    exp_ptr = (w + 1) % N;
  endtask

  task automatic test_random();
    logic [N-1:0] ack, ack_after, req; logic [3:0] val, mval; int lat, mlat, w;
    logic busy_after; logic [4*N-1:0] mx;
    draws_t d;
    for (int t = 0; t < 40; t++) begin
      req = 4'($urandom_range(1, 15));
      mx  = 16'($urandom);
      rand_draws(d);
      w = model_pick(req, exp_ptr);
      model_draw(mx[4*w +: 4], d, mval, mlat);
      bus.req = req; bus.max = mx;
      run_txn(d, 1'b1, req, 16'($urandom), ack, val, lat, ack_after, busy_after);
      bus.req = '0;
      n_checks += 3;
      if (ack !== (4'b0001 << w)) begin
        n_fail++; $display("FAIL rand_grant%0d: got %b expected %b", t, ack, 4'b0001 << w);
      end
      if (val !== mval || lat != mlat) begin
        n_fail++; $display("FAIL rand_value%0d: got %0d lat %0d expected %0d lat %0d", t, val, lat, mval, mlat);
      end
      if (ack_after !== '0) begin
        n_fail++; $display("FAIL rand_pulse%0d: got %b expected 0", t, ack_after);
      end
      exp_ptr = (w + 1) % N;
      tick();
    end
  endtask

  initial begin
    draws_t d;
    test_reset();
    for (int t = 0; t < MAX_TRIES; t++) d[t] = 4'd5;
    test_directed("single", 4'd9, d, 2, 4'd5);
    d = '{4'd12, 4'd7, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    test_directed("reject", 4'd3, d, 4, 4'd2);
    for (int t = 0; t < MAX_TRIES; t++) d[t] = 4'd15;
    test_directed("fallback", 4'd2, d, MAX_TRIES + 1, 4'd2);
    test_round_robin();
    test_drop_mid_draw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/rand_arbiter.md
# rand_arbiter

Round-robin arbiter that shares one 4-bit random source (the free-running Lfsr output, values 1..15) among N requesters. Each requester supplies an upper bound and receives one value in 1..bound. Values are drawn by rejection sampling with a bounded retry count. The block sits between the Lfsr and the game/control logic that needs random numbers, so that no two consumers ever receive the same draw.

## Interface
- N, 4, number of requesters (2..8)
- MAX_TRIES, 8, draws attempted per transaction before fallback (1..15)
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_rand  input  4  random nibble from Lfsr, sampled every DRAW cycle; always 1..15
- i_req  input  N  per-requester request level; hold high until own o_ack
- i_max  input  4N  per-requester bound; requester k uses i_max[4k+3:4k]; 0 means 15
- o_ack  output  N  one-hot, one-cycle pulse; qualifies o_value
- o_value  output  4  granted random value, valid only while o_ack != 0
- o_busy  output  1  high whenever state != S_IDLE

## Operation
- FSM states: S_IDLE, S_DRAW, S_DONE. Reset state: S_IDLE.
- Registers: rr_ptr (round-robin start index), idx_r (granted requester), max_r (4 bits), tries_r (4 bits), value_r (4 bits).
- S_IDLE:
  - If no i_req bit is set, stay.
  - Otherwise, select the first set bit scanning rr_ptr, rr_ptr+1, ... mod N. Latch idx_r.
  - Latch max_r = i_max[idx] (0 mapped to 15) and clear tries_r. Go to S_DRAW.
- S_DRAW, each cycle:
  - If i_rand <= max_r: value_r = i_rand, go to S_DONE.
  - Else, if tries_r == MAX_TRIES-1: value_r = max_r (fallback), go to S_DONE.
  - Else: tries_r++, stay in S_DRAW.
- S_DONE:
  - o_ack[idx_r] = 1 and o_value = value_r, for exactly one cycle.
  - rr_ptr = (idx_r+1) mod N. Go to S_IDLE.
- i_max is sampled only on entry to S_DRAW; later changes are ignored for the current transaction.
- A requester that drops i_req during S_DRAW still receives its o_ack pulse. The transaction is never aborted.
- A requester still holding i_req in the cycle after its ack is treated as a new request. It competes with lowest priority for that round.
- o_value is 0 whenever o_ack == 0.
- Reset mid-transaction: all outputs go to 0 immediately, the FSM returns to S_IDLE, rr_ptr = 0, and the pending grant is lost. The requester re-arbitrates after reset release if it still holds i_req.

## Timing
- Reset values: o_ack = 0, o_value = 0, o_busy = 0; rr_ptr = 0, idx_r = 0, max_r = 0, tries_r = 0, value_r = 0.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- Latency from i_req high (with block idle) to o_ack pulse:
  - minimum 2 cycles (IDLE→DRAW at edge 1, DRAW→DONE at edge 2, o_ack high during cycle 2);
  - maximum MAX_TRIES+1 cycles.
- Back-to-back throughput: one grant per 3..MAX_TRIES+2 cycles, since S_IDLE always costs one cycle.
- Starvation bound: a held request is granted within N-1 other transactions.
- Arbitration is evaluated only in S_IDLE. Requests arriving during S_DRAW/S_DONE wait.

## Test plan
- Reset/idle: assert i_rst_n=0 mid-S_DRAW → o_ack=0, o_value=0, o_busy=0 in the same cycle; after release with i_req=0 everything stays 0.
- Single accept: N=4, i_req=0001, i_max[3:0]=9, i_rand=5 → o_ack=0001 exactly 2 cycles later, o_value=5, one-cycle pulse.
- Rejection then accept: i_max=3, i_rand sequence 12,7,2 → o_ack after 4 cycles, o_value=2.
- Fallback: i_max=2, i_rand held at 15, MAX_TRIES=8 → o_ack after 9 cycles, o_value=2.
- Round-robin fairness: i_req=1111 held continuously, i_max all 0 (treated as 15) → grants in order 0001, 0010, 0100, 1000, 0001, each o_value equal to the i_rand sampled in its DRAW cycle.
- Drop mid-draw / bound latch: requester 2 raises i_req with i_max=4, then drops i_req and changes i_max to 15 during rejections of i_rand=10,10,1 → o_ack=0100 still pulses with o_value=1; next i_req=0100 is granted after rr_ptr=3 priority rules.
